// File: rtl/spike_event_encoder.sv
// rtl/spike_event_encoder.sv - neuron spike stream to AER event words with per-timestep markers and counts
// Event words are buffered in a FIFO whose head word is held in output registers.
module spike_event_encoder #(
    parameter int DEPTH      = 256,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              spike_in,
    input  logic              ts_start,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [ADDR_W-1:0] ev_addr,
    output logic              ev_spike,
    output logic              ev_last,
    output logic              ts_done,
    output logic [ADDR_W:0]   ts_spike_count,
    output logic              overflow,
    input  logic              clear_overflow
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int WORD_W = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]    FULL_OCC = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    ONE_OCC  = (PTR_W + 1)'(1);

    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  run_count;

    logic [ADDR_W-1:0] cur_idx;
    logic [CNT_W-1:0]  cur_count;
    logic [CNT_W-1:0]  sample_count;
    logic              is_last;
    logic              push_req;

    // ts_start re-aligns the index/count before the same-cycle sample is interpreted
    always_comb begin
        cur_idx      = ts_start ? '0 : idx;
        cur_count    = ts_start ? '0 : run_count;
        is_last      = (cur_idx == LAST_IDX);
        sample_count = cur_count + CNT_W'(spike_in);
        push_req     = valid_in && (spike_in || is_last);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx            <= '0;
            run_count      <= '0;
            ts_spike_count <= '0;
            ts_done        <= 1'b0;
        end else begin
            ts_done <= valid_in && is_last;
            if (valid_in) begin
                if (is_last) begin
                    idx            <= '0;
                    run_count      <= '0;
                    ts_spike_count <= sample_count;
                end else begin
                    idx       <= cur_idx + ADDR_W'(1);
                    run_count <= sample_count;
                end
            end else if (ts_start) begin
                idx       <= '0;
                run_count <= '0;
            end
        end
    end

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    occ;
    logic [PTR_W:0]    occ_next;
    logic              pop;
    logic              push_acc;
    logic              drop;
    logic [WORD_W-1:0] push_word;
    logic [WORD_W-1:0] head_next;

    always_comb begin
        pop       = ev_valid && ev_ready;
        push_acc  = push_req && ((occ != FULL_OCC) || pop);
        drop      = push_req && !push_acc;
        push_word = {cur_idx, spike_in, is_last};
        occ_next  = occ + (PTR_W + 1)'(push_acc) - (PTR_W + 1)'(pop);
        head_next = {ev_addr, ev_spike, ev_last};
        // The incoming word becomes head only when nothing older survives this cycle
        if (push_acc && ((occ == '0) || ((occ == ONE_OCC) && pop))) begin
            head_next = push_word;
        end else if (pop) begin
            head_next = mem[rd_ptr + PTR_W'(1)];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            ev_valid <= 1'b0;
            ev_addr  <= '0;
            ev_spike <= 1'b0;
            ev_last  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ                         <= occ_next;
            ev_valid                    <= (occ_next != '0);
            {ev_addr, ev_spike, ev_last} <= head_next;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= push_word;
        end
    end
endmodule

// File: tb/tb_spike_event_encoder.sv
// tb/tb_spike_event_encoder.sv - self-checking bench for spike_event_encoder (DEPTH=8, FIFO_DEPTH=4)
module tb_spike_event_encoder;
    localparam int DEPTH      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid_in = 1'b0;
    logic              spike_in = 1'b0;
    logic              ts_start = 1'b0;
    logic              ev_ready = 1'b0;
    logic              clear_overflow = 1'b0;
    logic              ev_valid;
    logic [ADDR_W-1:0] ev_addr;
    logic              ev_spike;
    logic              ev_last;
    logic              ts_done;
    logic [ADDR_W:0]   ts_spike_count;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;

    spike_event_encoder #(.DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .spike_in(spike_in), .ts_start(ts_start),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_spike(ev_spike),
        .ev_last(ev_last), .ts_done(ts_done), .ts_spike_count(ts_spike_count),
        .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: words are {addr, spike, last}
    logic [4:0] m_q[$];
    logic [4:0] popped[$];
    logic [4:0] dut_got[$];
    int m_idx = 0;
    int m_cnt = 0;
    int m_ts_count = 0;
    bit m_ts_done = 0;
    bit m_ovf = 0;

    always @(posedge clk or negedge rst) begin : model_b
        bit pop;
        bit push;
        logic [4:0] w;
        if (!rst) begin
            m_q.delete();
            m_idx = 0; m_cnt = 0; m_ts_count = 0; m_ts_done = 0; m_ovf = 0;
        end else begin
            pop = (m_q.size() > 0) && ev_ready;
            push = 0;
            w = '0;
            m_ts_done = 0;
            if (ts_start) begin
                m_idx = 0;
                m_cnt = 0;
            end
            if (valid_in) begin
                m_cnt += int'(spike_in);
                if (m_idx == DEPTH - 1) begin
                    push = 1;
                    w = {3'(m_idx), spike_in, 1'b1};
                    m_ts_count = m_cnt;
                    m_cnt = 0;
                    m_ts_done = 1;
                    m_idx = 0;
                end else begin
                    if (spike_in) begin
                        push = 1;
                        w = {3'(m_idx), 1'b1, 1'b0};
                    end
                    m_idx = m_idx + 1;
                end
            end
            if (clear_overflow) m_ovf = 0;
            if (pop) popped.push_back(m_q.pop_front());
            if (push) begin
                if (m_q.size() < FIFO_DEPTH) m_q.push_back(w);
                else m_ovf = 1;
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic ts, input logic clr);
        valid_in = v; spike_in = s; ts_start = ts; clear_overflow = clr;
        #1;
        if (ev_valid && ev_ready) dut_got.push_back({ev_addr, ev_spike, ev_last});
        @(negedge clk);
    endtask

    task automatic run_ts(input logic [DEPTH-1:0] spikes);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, spikes[i], 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid got=%0b exp=0", ev_valid); end
        n_checks++; if (ts_done !== 1'b0) begin n_fail++; $display("FAIL reset_ts_done got=%0b exp=0", ts_done); end
        n_checks++; if (ts_spike_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", ts_spike_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        n_checks++; if ({ev_addr, ev_spike, ev_last} !== 5'd0) begin n_fail++; $display("FAIL reset_ev_word got=%h exp=0", {ev_addr, ev_spike, ev_last}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [4:0] exp_w[$];
        int pulses = 0;
        exp_w = '{5'b00110, 5'b01110, 5'b11111};
        ev_ready = 1'b1;
        dut_got.delete();
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (i < DEPTH) drive(1'b1, (i == 1 || i == 3 || i == 7), 1'b0, 1'b0);
            else drive(1'b0, 1'b0, 1'b0, 1'b0);
            if (ts_done === 1'b1) pulses++;
        end
        n_checks++; if (dut_got.size() != 3) begin n_fail++; $display("FAIL basic_words got=%0d exp=3", dut_got.size()); end
        for (int i = 0; i < 3 && i < dut_got.size(); i++) begin
            n_checks++; if (dut_got[i] !== exp_w[i]) begin n_fail++; $display("FAIL basic_word%0d got=%b exp=%b", i, dut_got[i], exp_w[i]); end
        end
        n_checks++; if (ts_spike_count !== 4'd3) begin n_fail++; $display("FAIL basic_count got=%0d exp=3", ts_spike_count); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL basic_ts_done_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_no_spike;
        ev_ready = 1'b1;
        dut_got.delete();
        run_ts(8'h00);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (dut_got.size() != 1) begin n_fail++; $display("FAIL nospike_words got=%0d exp=1", dut_got.size()); end
        else begin
            n_checks++; if (dut_got[0] !== 5'b11101) begin n_fail++; $display("FAIL nospike_marker got=%b exp=11101", dut_got[0]); end
        end
        n_checks++; if (ts_spike_count !== 4'd0) begin n_fail++; $display("FAIL nospike_count got=%0d exp=0", ts_spike_count); end
    endtask

    task automatic test_overflow;
        ev_ready = 1'b0;
        dut_got.delete();
        run_ts(8'hFF);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
        n_checks++; if (ts_spike_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got=%0d exp=8", ts_spike_count); end
        n_checks++; if (ev_valid !== 1'b1 || {ev_addr, ev_spike, ev_last} !== 5'b00010) begin n_fail++; $display("FAIL ovf_head_stable got=%b/%b exp=1/00010", ev_valid, {ev_addr, ev_spike, ev_last}); end
        ev_ready = 1'b1;
        repeat (6) drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (dut_got.size() != 4) begin n_fail++; $display("FAIL ovf_kept got=%0d exp=4", dut_got.size()); end
        for (int i = 0; i < 4 && i < dut_got.size(); i++) begin
            n_checks++; if (dut_got[i] !== {3'(i), 2'b10}) begin n_fail++; $display("FAIL ovf_word%0d got=%b exp=%b", i, dut_got[i], {3'(i), 2'b10}); end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
    endtask

    task automatic test_back_to_back;
        ev_ready = 1'b0;
        dut_got.delete();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        ev_ready = 1'b1;
        for (int i = 4; i < DEPTH; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (dut_got.size() != 4) begin n_fail++; $display("FAIL b2b_popped_while_full got=%0d exp=4", dut_got.size()); end
        repeat (6) drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (dut_got.size() != 8) begin n_fail++; $display("FAIL b2b_words got=%0d exp=8", dut_got.size()); end
        for (int i = 0; i < 8 && i < dut_got.size(); i++) begin
            n_checks++; if (dut_got[i] !== {3'(i), 1'b1, (i == 7)}) begin n_fail++; $display("FAIL b2b_word%0d got=%b exp=%b", i, dut_got[i], {3'(i), 1'b1, (i == 7)}); end
        end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_no_drop got=%0b exp=0", overflow); end
    endtask

    task automatic test_ts_start;
        ev_ready = 1'b1;
        dut_got.delete();
        repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (6) drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (dut_got.size() != 1) begin n_fail++; $display("FAIL tss_early_words got=%0d exp=1", dut_got.size()); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (dut_got.size() != 2) begin n_fail++; $display("FAIL tss_words got=%0d exp=2", dut_got.size()); end
        else begin
            n_checks++; if (dut_got[0] !== 5'b00010) begin n_fail++; $display("FAIL tss_realigned got=%b exp=00010", dut_got[0]); end
            n_checks++; if (dut_got[1] !== 5'b11101) begin n_fail++; $display("FAIL tss_marker got=%b exp=11101", dut_got[1]); end
        end
        n_checks++; if (ts_spike_count !== 4'd1) begin n_fail++; $display("FAIL tss_count got=%0d exp=1", ts_spike_count); end
    endtask

    task automatic test_random;
        int errs = 0;
        dut_got.delete();
        popped.delete();
        for (int c = 0; c < 600; c++) begin
            ev_ready = ($urandom_range(0, 1) == 1);
            drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 24) == 0), ($urandom_range(0, 29) == 0));
            n_checks++; if (ev_valid !== (m_q.size() != 0)) begin n_fail++; errs++; $display("FAIL rnd_ev_valid cyc=%0d got=%b exp=%b", c, ev_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                n_checks++; if ({ev_addr, ev_spike, ev_last} !== m_q[0]) begin n_fail++; errs++; $display("FAIL rnd_head cyc=%0d got=%b exp=%b", c, {ev_addr, ev_spike, ev_last}, m_q[0]); end
            end
            n_checks++; if (overflow !== m_ovf) begin n_fail++; errs++; $display("FAIL rnd_overflow cyc=%0d got=%b exp=%b", c, overflow, m_ovf); end
            n_checks++; if (ts_done !== m_ts_done) begin n_fail++; errs++; $display("FAIL rnd_ts_done cyc=%0d got=%b exp=%b", c, ts_done, m_ts_done); end
            n_checks++; if (ts_spike_count !== 4'(m_ts_count)) begin n_fail++; errs++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, ts_spike_count, m_ts_count); end
            if (errs > 10) break;
        end
        ev_ready = 1'b1;
        repeat (FIFO_DEPTH + 2) drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (dut_got != popped) begin n_fail++; $display("FAIL rnd_stream got_words=%0d exp_words=%0d", dut_got.size(), popped.size()); end
    endtask

    task automatic test_reset_mid;
        ev_ready = 1'b0;
        dut_got.delete();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < DEPTH; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        valid_in = 1'b0; spike_in = 1'b0;
        n_checks++; if (overflow !== 1'b1 || ev_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got=%b/%b exp=1/1", overflow, ev_valid); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ev_valid got=%0b exp=0", ev_valid); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_overflow got=%0b exp=0", overflow); end
        n_checks++; if (ts_spike_count !== 4'd0) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=0", ts_spike_count); end
        @(negedge clk);
        rst = 1'b1;
        ev_ready = 1'b1;
        run_ts(8'h01);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (dut_got.size() != 2) begin n_fail++; $display("FAIL rstmid_words got=%0d exp=2", dut_got.size()); end
        else begin
            n_checks++; if (dut_got[0] !== 5'b00010 || dut_got[1] !== 5'b11101) begin n_fail++; $display("FAIL rstmid_idx got=%b,%b exp=00010,11101", dut_got[0], dut_got[1]); end
        end
        n_checks++; if (ts_spike_count !== 4'd1) begin n_fail++; $display("FAIL rstmid_run_count got=%0d exp=1", ts_spike_count); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_no_spike;
        test_overflow;
        test_back_to_back;
        test_ts_start;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
